// File: rtl/axi_r_burst_buffer.sv
// AXI R-channel beat buffer: circular FIFO with first-word fall-through, optional
// burst-aware store-and-forward release, occupancy/burst status and an optional
// error-response counter (enabled by defining AXI_RBUF_ERR_CNT_EN).
module axi_r_burst_buffer #(
  parameter int ID_WIDTH     = 4,
  parameter int DATA_WIDTH   = 64,
  parameter int USER_WIDTH   = 6,
  parameter int BUFFER_DEPTH = 8,
  parameter int STORE_FWD    = 0,
  parameter int CNT_WIDTH    = $clog2(BUFFER_DEPTH + 1)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  test_en_i,
  input  logic                  slave_valid_i,
  input  logic [DATA_WIDTH-1:0] slave_data_i,
  input  logic [1:0]            slave_resp_i,
  input  logic [USER_WIDTH-1:0] slave_user_i,
  input  logic [ID_WIDTH-1:0]   slave_id_i,
  input  logic                  slave_last_i,
  output logic                  slave_ready_o,
  output logic                  master_valid_o,
  output logic [DATA_WIDTH-1:0] master_data_o,
  output logic [1:0]            master_resp_o,
  output logic [USER_WIDTH-1:0] master_user_o,
  output logic [ID_WIDTH-1:0]   master_id_o,
  output logic                  master_last_o,
  input  logic                  master_ready_i,
  output logic [CNT_WIDTH-1:0]  fill_o,
  output logic [CNT_WIDTH-1:0]  bursts_o,
  output logic                  full_o,
  output logic                  empty_o,
  output logic [15:0]           err_cnt_o
);

  localparam int BeatW = ID_WIDTH + USER_WIDTH + 2 + 1 + DATA_WIDTH;
  localparam int PtrW  = $clog2(BUFFER_DEPTH);

  typedef enum logic {StFill, StDrain} state_e;

  logic [BeatW-1:0]     mem_q [BUFFER_DEPTH];
  logic [PtrW-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_WIDTH-1:0] fill_q, fill_d, bursts_q, bursts_d;
  state_e               state_q, state_d;
  logic                 push, pop, push_last, pop_last;

  // Test mode has no functional effect.
  logic unused_test_en;
  assign unused_test_en = test_en_i;

  // Status derives from the registered count, so ready never depends on a same-cycle pop.
  assign full_o        = (fill_q == CNT_WIDTH'(BUFFER_DEPTH));
  assign empty_o       = (fill_q == '0);
  assign fill_o        = fill_q;
  assign bursts_o      = bursts_q;
  assign slave_ready_o = !full_o;

  assign push      = slave_valid_i & slave_ready_o;
  assign pop       = master_valid_o & master_ready_i;
  assign push_last = push & slave_last_i;
  assign pop_last  = pop & master_last_o;

  assign {master_id_o, master_user_o, master_resp_o, master_last_o, master_data_o} =
      mem_q[rd_ptr_q];

  // Output valid: cut-through shows any stored beat; store-and-forward holds beats in
  // FILL until a complete burst is present.
  always_comb begin
    master_valid_o = !empty_o;
    if (STORE_FWD != 0 && state_q == StFill) begin
      master_valid_o = !empty_o && (bursts_q != '0);
    end
  end

  // Next-state for pointers, occupancy and burst count.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    fill_d   = fill_q;
    bursts_d = bursts_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    if (push && !pop)      fill_d = fill_q + 1'b1;
    else if (!push && pop) fill_d = fill_q - 1'b1;
    if (push_last && !pop_last)      bursts_d = bursts_q + 1'b1;
    else if (!push_last && pop_last) bursts_d = bursts_q - 1'b1;
  end

  // Store-and-forward FSM: a full buffer with no complete burst must drain to avoid deadlock.
  always_comb begin
    state_d = state_q;
    if (STORE_FWD != 0) begin
      case (state_q)
        StFill:  if (full_o && bursts_q == '0) state_d = StDrain;
        StDrain: if (pop_last) state_d = StFill;
        default: state_d = StFill;
      endcase
    end
  end

  // Control registers; reset discards every stored beat.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      fill_q   <= '0;
      bursts_q <= '0;
      state_q  <= StFill;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      fill_q   <= fill_d;
      bursts_q <= bursts_d;
      state_q  <= state_d;
    end
  end

  // Beat storage; contents are don't-care until written, so no reset.
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {slave_id_i, slave_user_i, slave_resp_i, slave_last_i, slave_data_i};
    end
  end

`ifdef AXI_RBUF_ERR_CNT_EN
  logic [15:0] err_cnt_q;

  // Count accepted SLVERR/DECERR beats, saturating.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      err_cnt_q <= '0;
    end else if (push && slave_resp_i[1] && err_cnt_q != 16'hFFFF) begin
      err_cnt_q <= err_cnt_q + 16'd1;
    end
  end

  assign err_cnt_o = err_cnt_q;
`else
  assign err_cnt_o = 16'h0000;
`endif

endmodule

// File: tb/tb_axi_r_burst_buffer.sv
// Bench for axi_r_burst_buffer: one cut-through and one store-and-forward instance,
// beats checked against a per-instance scoreboard queue.
module tb_axi_r_burst_buffer;

  typedef logic [76:0] beat_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic        sv [2];
  logic [63:0] sd [2];
  logic [1:0]  sr [2];
  logic [5:0]  su [2];
  logic [3:0]  si [2];
  logic        sl [2];
  logic        sready [2];
  logic        mvalid [2];
  logic [63:0] md [2];
  logic [1:0]  mr [2];
  logic [5:0]  mu [2];
  logic [3:0]  mi [2];
  logic        ml [2];
  logic        mready [2];
  logic [3:0]  fill [2];
  logic [3:0]  bursts [2];
  logic        full [2];
  logic        empty [2];
  logic [15:0] err_cnt [2];

  beat_t exp_q [2][$];
  int    n_checks = 0;
  int    n_errors = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    axi_r_burst_buffer #(
      .ID_WIDTH    (4),
      .DATA_WIDTH  (64),
      .USER_WIDTH  (6),
      .BUFFER_DEPTH(8),
      .STORE_FWD   (g)
    ) u_dut (
      .clk_i         (clk),
      .rst_i         (rst),
      .test_en_i     (1'b0),
      .slave_valid_i (sv[g]),
      .slave_data_i  (sd[g]),
      .slave_resp_i  (sr[g]),
      .slave_user_i  (su[g]),
      .slave_id_i    (si[g]),
      .slave_last_i  (sl[g]),
      .slave_ready_o (sready[g]),
      .master_valid_o(mvalid[g]),
      .master_data_o (md[g]),
      .master_resp_o (mr[g]),
      .master_user_o (mu[g]),
      .master_id_o   (mi[g]),
      .master_last_o (ml[g]),
      .master_ready_i(mready[g]),
      .fill_o        (fill[g]),
      .bursts_o      (bursts[g]),
      .full_o        (full[g]),
      .empty_o       (empty[g]),
      .err_cnt_o     (err_cnt[g])
    );
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic beat_t mk(input logic [63:0] d, input logic [1:0] r, input logic [5:0] u,
                               input logic [3:0] id, input logic l);
    return {id, u, r, l, d};
  endfunction

  // Scoreboard: pop before push, since a beat can never leave in its push cycle.
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        exp_q[i].delete();
      end else begin
        if (mvalid[i] && mready[i]) begin
          check("sb_has_beat", 128'(exp_q[i].size() != 0), 128'(1));
          if (exp_q[i].size() != 0) begin
            check($sformatf("beat%0d", i), 128'(mk(md[i], mr[i], mu[i], mi[i], ml[i])),
                  128'(exp_q[i].pop_front()));
          end
        end
        if (sv[i] && sready[i]) exp_q[i].push_back(mk(sd[i], sr[i], su[i], si[i], sl[i]));
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 of the cycle after the beat is accepted.
  task automatic send(input int i, input logic [63:0] d, input logic [1:0] r, input logic l);
    int   n;
    logic ok;
    n  = 0;
    ok = 1'b0;
    sv[i] = 1'b1; sd[i] = d; sr[i] = r; su[i] = d[5:0]; si[i] = d[9:6]; sl[i] = l;
    while (!ok && n < 100) begin
      @(negedge clk);
      ok = sready[i];
      n++;
      @(posedge clk);
      #1;
    end
    sv[i] = 1'b0;
    if (!ok) check("send_timeout", 128'(ok), 128'(1));
  endtask

  task automatic wait_empty(input int i);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!empty[i] && n < 200);
    check("drained", 128'(empty[i]), 128'(1));
    check("sb_empty", 128'(exp_q[i].size()), 128'(0));
    @(posedge clk);
    #1;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 2; i++) begin
      sv[i] = 1'b0; sd[i] = '0; sr[i] = '0; su[i] = '0; si[i] = '0; sl[i] = 1'b0;
      mready[i] = 1'b0;
    end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      check("rst_fill", 128'(fill[i]), 128'(0));
      check("rst_bursts", 128'(bursts[i]), 128'(0));
      check("rst_empty", 128'(empty[i]), 128'(1));
      check("rst_full", 128'(full[i]), 128'(0));
      check("rst_mvalid", 128'(mvalid[i]), 128'(0));
      check("rst_sready", 128'(sready[i]), 128'(1));
      check("rst_errcnt", 128'(err_cnt[i]), 128'(0));
    end
    @(posedge clk);
    #1;

    // Cut-through: three-beat burst with sink ready.
    mready[0] = 1'b1;
    send(0, 64'hA1, 2'b00, 1'b0);
    check("ct_valid_next", 128'(mvalid[0]), 128'(1));
    check("ct_head_a1", 128'(md[0]), 128'(64'hA1));
    send(0, 64'hA2, 2'b10, 1'b0);
    send(0, 64'hA3, 2'b01, 1'b1);
    wait_empty(0);
    check("ct_fill_zero", 128'(fill[0]), 128'(0));

    // Fill to full with sink stalled, then a ninth beat held until the first pop.
    mready[0] = 1'b0;
    for (int k = 0; k < 8; k++) send(0, 64'hB0 + 64'(k), 2'(k), k[1]);
    check("full_flag", 128'(full[0]), 128'(1));
    check("full_sready", 128'(sready[0]), 128'(0));
    check("full_fill", 128'(fill[0]), 128'(8));
    check("full_bursts", 128'(bursts[0]), 128'(4));
    check("stall_head", 128'(md[0]), 128'(64'hB0));
    fork
      send(0, 64'hB8, 2'b00, 1'b1);
      begin
        repeat (3) begin
          @(negedge clk);
          check("ninth_held", 128'(fill[0]), 128'(8));
        end
        @(posedge clk);
        #1 mready[0] = 1'b1;
        @(negedge clk);
        check("no_push_while_full", 128'(sready[0]), 128'(0));
        @(negedge clk);
        check("ready_after_pop", 128'(sready[0]), 128'(1));
        check("fill_after_pop", 128'(fill[0]), 128'(7));
      end
    join
    wait_empty(0);

    // Store-and-forward: nothing leaves until the last beat is stored.
    mready[1] = 1'b1;
    for (int k = 0; k < 3; k++) begin
      send(1, 64'hC0 + 64'(k), 2'b00, 1'b0);
      check("sf_hold", 128'(mvalid[1]), 128'(0));
    end
    send(1, 64'hC3, 2'b00, 1'b1);
    check("sf_release", 128'(mvalid[1]), 128'(1));
    check("sf_bursts", 128'(bursts[1]), 128'(1));
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("sf_back_to_back", 128'(mvalid[1]), 128'(1));
    end
    @(negedge clk);
    check("sf_done", 128'(mvalid[1]), 128'(0));
    wait_empty(1);

    // Store-and-forward: burst longer than the buffer forces DRAIN.
    for (int k = 0; k < 8; k++) send(1, 64'hD0 + 64'(k), 2'b00, 1'b0);
    check("long_full", 128'(full[1]), 128'(1));
    check("long_fill_hold", 128'(mvalid[1]), 128'(0));
    @(posedge clk);
    #1;
    check("long_drain", 128'(mvalid[1]), 128'(1));
    for (int k = 8; k < 12; k++) send(1, 64'hD0 + 64'(k), 2'b00, k == 11);
    wait_empty(1);
    send(1, 64'hE0, 2'b00, 1'b0);
    check("back_to_fill", 128'(mvalid[1]), 128'(0));
    check("back_to_fill_cnt", 128'(fill[1]), 128'(1));
    send(1, 64'hE1, 2'b00, 1'b1);
    wait_empty(1);

    // Reset mid-operation discards buffered beats.
    mready[0] = 1'b0;
    for (int k = 0; k < 5; k++) send(0, 64'hF0 + 64'(k), 2'b00, k == 2);
    check("pre_rst_fill", 128'(fill[0]), 128'(5));
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    check("mid_rst_fill", 128'(fill[0]), 128'(0));
    check("mid_rst_bursts", 128'(bursts[0]), 128'(0));
    check("mid_rst_mvalid", 128'(mvalid[0]), 128'(0));
    check("mid_rst_empty", 128'(empty[0]), 128'(1));
    mready[0] = 1'b1;
    send(0, 64'h5A, 2'b00, 1'b1);
    wait_empty(0);

`ifdef AXI_RBUF_ERR_CNT_EN
    send(0, 64'h61, 2'b10, 1'b0);
    send(0, 64'h62, 2'b10, 1'b0);
    send(0, 64'h63, 2'b10, 1'b0);
    send(0, 64'h64, 2'b11, 1'b0);
    send(0, 64'h65, 2'b00, 1'b0);
    send(0, 64'h66, 2'b00, 1'b1);
    wait_empty(0);
    check("err_cnt", 128'(err_cnt[0]), 128'(4));
`else
    send(0, 64'h61, 2'b10, 1'b1);
    wait_empty(0);
    check("err_cnt_tied", 128'(err_cnt[0]), 128'(0));
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
